// File: rtl/gray16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gray16_pkg
//  Purpose  : Shared definitions for the 16-entry gray pointer crossing.
//             Holds the 5-bit code table, pointer sizing constants and the
//             gray<->binary conversion functions. The encoder and decoder
//             sides both import this package.
//  Contents : G0..G15, PTR_W, PTR_DEPTH, ptr_t, gray2bin16(), bin2gray16()
//  Revision : 1.0  initial release
// ============================================================================
package gray16_pkg;

  localparam int PTR_W     = 5;
  localparam int PTR_DEPTH = 16;

  typedef logic [PTR_W-1:0] ptr_t;

  // Reflected gray table; bit4 is always 0 for a legal code.
  localparam ptr_t G0  = 5'b00000;
  localparam ptr_t G1  = 5'b00001;
  localparam ptr_t G2  = 5'b00011;
  localparam ptr_t G3  = 5'b00010;
  localparam ptr_t G4  = 5'b00110;
  localparam ptr_t G5  = 5'b00111;
  localparam ptr_t G6  = 5'b00101;
  localparam ptr_t G7  = 5'b00100;
  localparam ptr_t G8  = 5'b01100;
  localparam ptr_t G9  = 5'b01101;
  localparam ptr_t G10 = 5'b01111;
  localparam ptr_t G11 = 5'b01110;
  localparam ptr_t G12 = 5'b01010;
  localparam ptr_t G13 = 5'b01011;
  localparam ptr_t G14 = 5'b01001;
  localparam ptr_t G15 = 5'b01000;

  // Gray to binary over the low 4 bits; result bit4 is forced to 0.
  function automatic ptr_t gray2bin16(input ptr_t g);
    ptr_t b;
    b[4] = 1'b0;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // Binary to gray over the low 4 bits; result bit4 is forced to 0.
  function automatic ptr_t bin2gray16(input ptr_t b);
    return {1'b0, b[3:0] ^ {1'b0, b[3:1]}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/graydecoder_16_sync_sync_cell.sv
`default_nettype none
// ============================================================================
//  Module   : sync_cell
//  Purpose  : N-flop single-bit synchroniser with asynchronous active-high
//             reset. The input is launched from a foreign clock domain.
//  Ports    : clk   - local clock
//             reset - asynchronous active-high reset, clears the chain
//             i_d   - asynchronous input bit
//             o_q   - synchronised output bit (last flop of the chain)
//  Params   : N     - chain depth, 2..4
//  Revision : 1.0  initial release
// ============================================================================
module sync_cell #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[N-2:0], i_d};
    end
  end

  assign o_q = r_q[N-1];

endmodule
`default_nettype wire

// File: rtl/graydecoder_16_sync.sv
`default_nettype none
// ============================================================================
//  Module   : graydecoder_16_sync
//  Purpose  : Receive side of the 16-entry gray pointer crossing in the
//             PCS 25G elastic buffer. Synchronises a remote gray pointer,
//             decodes it to binary, and flags illegal codes and
//             non-monotonic pointer steps.
//  Ports    : clk      - local clock, posedge
//             reset    - asynchronous active-high reset
//             inp      - 5-bit gray pointer from remote domain (bit4 = 0)
//             err_clr  - synchronous clear of the sticky error flags
//             outp     - decoded binary pointer 0..15 (bit4 always 0)
//             out_vld  - outp holds a synchronised post-reset sample
//             err_code - sticky: illegal gray code seen
//             err_step - sticky: pointer step outside {0,+1} mod 16
//  Params   : SYNC_STAGES - synchroniser depth, 2..4
//  Config   : GRAYDEC_STEP_CHECK_EN - when defined, builds the step
//             comparator and err_step flop; otherwise err_step is tied 0.
//  Revision : 1.0  initial release
// ============================================================================
module graydecoder_16_sync
  import gray16_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PTR_W-1:0] inp,
  input  logic             err_clr,
  output logic [PTR_W-1:0] outp,
  output logic             out_vld,
  output logic             err_code,
  output logic             err_step
);

  localparam int FILL_W = 3;

  logic [PTR_W-1:0]  w_sync;
  logic [PTR_W-1:0]  w_dec;
  logic              w_legal;
  logic              w_fill_done;

  logic [PTR_W-1:0]  r_outp;
  logic              r_vld;
  logic              r_err_code;
  logic [FILL_W-1:0] r_fill;

  generate
    for (genvar gi = 0; gi < PTR_W; gi++) begin : g_sync
      sync_cell #(
        .N (SYNC_STAGES)
      ) u_sync_cell (
        .clk   (clk),
        .reset (reset),
        .i_d   (inp[gi]),
        .o_q   (w_sync[gi])
      );
    end
  endgenerate

  assign w_dec   = gray2bin16(w_sync);
  assign w_legal = ~w_sync[PTR_W-1];

  // The last sync flop carries a post-reset sample once the counter has
  // seen SYNC_STAGES edges; before that it only holds reset zeros.
  assign w_fill_done = (r_fill == FILL_W'(SYNC_STAGES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fill     <= '0;
      r_outp     <= '0;
      r_vld      <= 1'b0;
      r_err_code <= 1'b0;
    end else begin
      if (!w_fill_done) begin
        r_fill <= r_fill + 1'b1;
      end
      if (w_fill_done) begin
        r_vld <= 1'b1;
        // Illegal codes leave outp untouched so it remains the step reference.
        if (w_legal) begin
          r_outp <= w_dec;
        end
      end
      // Set wins over clear.
      r_err_code <= (w_fill_done & ~w_legal) | (r_err_code & ~err_clr);
    end
  end

  assign outp     = r_outp;
  assign out_vld  = r_vld;
  assign err_code = r_err_code;

`ifdef GRAYDEC_STEP_CHECK_EN
  logic [3:0] w_delta;
  logic       w_step_bad;
  logic       r_err_step;

  // Modulo-16 difference; 15 -> 0 gives 1 and is therefore legal.
  assign w_delta    = w_dec[3:0] - r_outp[3:0];
  assign w_step_bad = w_fill_done & w_legal & r_vld & (w_delta > 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_step <= 1'b0;
    end else begin
      r_err_step <= w_step_bad | (r_err_step & ~err_clr);
    end
  end

  assign err_step = r_err_step;
`else
  assign err_step = 1'b0;
`endif

endmodule
`default_nettype wire
